// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad legend, key function codes and default parameters
package keypad_pkg;

    localparam int DEFAULT_SCAN_DIV   = 50000;
    localparam int DEFAULT_DEB_FRAMES = 4;
    localparam int MAX_DIGITS         = 6;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        DIGIT     = 3'd1,
        BACKSPACE = 3'd2,
        CLEAR     = 3'd3,
        ENTER     = 3'd4
    } key_fn_e;

    typedef struct packed {
        key_fn_e    fn;
        logic [3:0] digit;
    } key_action_t;

    // Legend: row0 1 2 3 A / row1 4 5 6 B / row2 7 8 9 C / row3 * 0 # D
    function automatic key_action_t decode_key(input logic [3:0] code);
        key_action_t a;
        a.fn    = NONE;
        a.digit = 4'd0;
        case (code)
            4'd0:  begin a.fn = DIGIT; a.digit = 4'd1; end
            4'd1:  begin a.fn = DIGIT; a.digit = 4'd2; end
            4'd2:  begin a.fn = DIGIT; a.digit = 4'd3; end
            4'd3:  a.fn = BACKSPACE;
            4'd4:  begin a.fn = DIGIT; a.digit = 4'd4; end
            4'd5:  begin a.fn = DIGIT; a.digit = 4'd5; end
            4'd6:  begin a.fn = DIGIT; a.digit = 4'd6; end
            4'd8:  begin a.fn = DIGIT; a.digit = 4'd7; end
            4'd9:  begin a.fn = DIGIT; a.digit = 4'd8; end
            4'd10: begin a.fn = DIGIT; a.digit = 4'd9; end
            4'd12: a.fn = CLEAR;
            4'd13: begin a.fn = DIGIT; a.digit = 4'd0; end
            4'd14: a.fn = ENTER;
            default: a.fn = NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - row scanning, column synchronizer, frame debounce and key-press event detection
module keypad_scan import keypad_pkg::*; #(
    parameter int SCAN_DIV   = DEFAULT_SCAN_DIV,
    parameter int DEB_FRAMES = DEFAULT_DEB_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] key_row,
    input  logic [3:0] key_col,
    output logic       ev_valid,
    output logic [3:0] ev_code
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEB_FRAMES + 1);

    logic [3:0]       col_s1;
    logic [3:0]       col_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [11:0]      frame_acc;
    logic [15:0]      last_frame;
    logic [CNT_W-1:0] stable_cnt;
    logic [15:0]      accepted;

    logic             row_end;
    logic             frame_end;
    logic [15:0]      new_frame;
    logic             same;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic [4:0]       n_set;
    logic [3:0]       one_idx;
    logic             ev_fire;

    // Active-low one-hot row drive follows the current row index
    always_comb begin
        key_row = ~(4'b0001 << row_idx);
    end

    // Two-flop synchronizer; idle columns read high (pulled up)
    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            col_s1 <= key_col;
            col_s2 <= col_s1;
        end
    end

    // Frame assembly, stability count and single-key press detection
    always_comb begin
        row_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
        frame_end = row_end && (row_idx == 2'd3);
        new_frame = {~col_s2, frame_acc};
        same      = (new_frame == last_frame);
        if (!same)
            cnt_next = CNT_W'(1);
        else if (stable_cnt == CNT_W'(DEB_FRAMES))
            cnt_next = stable_cnt;
        else
            cnt_next = stable_cnt + CNT_W'(1);
        // accept only on the frame that first reaches the threshold
        accept = frame_end && (cnt_next == CNT_W'(DEB_FRAMES))
                 && !(same && (stable_cnt == CNT_W'(DEB_FRAMES)));
        n_set   = 5'd0;
        one_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (new_frame[i]) begin
                n_set   = n_set + 5'd1;
                one_idx = 4'(i);
            end
        end
        // only a clean 0-keys -> 1-key accepted transition is a press
        ev_fire = accept && (accepted == 16'd0) && (n_set == 5'd1);
    end

    // Scan timing, frame history and registered event output
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            frame_acc  <= 12'd0;
            last_frame <= 16'd0;
            stable_cnt <= '0;
            accepted   <= 16'd0;
            ev_valid   <= 1'b0;
            ev_code    <= 4'd0;
        end else begin
            ev_valid <= 1'b0;
            if (row_end) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                case (row_idx)
                    2'd0:    frame_acc[3:0]  <= ~col_s2;
                    2'd1:    frame_acc[7:4]  <= ~col_s2;
                    2'd2:    frame_acc[11:8] <= ~col_s2;
                    default: ;
                endcase
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (frame_end) begin
                last_frame <= new_frame;
                stable_cnt <= cnt_next;
                if (accept) begin
                    accepted <= new_frame;
                    ev_valid <= ev_fire;
                    ev_code  <= one_idx;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad number entry top; KEYPAD_BCD_OUT_EN adds entry_bcd output
module keypad_entry import keypad_pkg::*; #(
    parameter int SCAN_DIV   = DEFAULT_SCAN_DIV,
    parameter int DEB_FRAMES = DEFAULT_DEB_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  key_row,
    input  logic [3:0]  key_col,
    output logic [3:0]  key_code,
    output logic        key_pulse,
    output logic [19:0] entry,
    output logic [2:0]  digit_cnt,
    output logic        overflow,
    output logic [19:0] value,
    output logic        value_valid
`ifdef KEYPAD_BCD_OUT_EN
    ,
    output logic [23:0] entry_bcd
`endif
);

    logic        ev_valid;
    logic [3:0]  ev_code;
    key_action_t act;
    logic [19:0] entry_n;
    logic [2:0]  cnt_n;
    logic        ovf_n;
    logic [19:0] value_n;
    logic        vv_n;
`ifdef KEYPAD_BCD_OUT_EN
    logic [23:0] bcd_n;
`endif

    keypad_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_FRAMES (DEB_FRAMES)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .ev_valid (ev_valid),
        .ev_code  (ev_code)
    );

    // Decode the key event and compute the next accumulator state
    always_comb begin
        act     = decode_key(ev_code);
        entry_n = entry;
        cnt_n   = digit_cnt;
        ovf_n   = overflow;
        value_n = value;
        vv_n    = 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
        bcd_n   = entry_bcd;
`endif
        if (ev_valid) begin
            case (act.fn)
                DIGIT: begin
                    if (digit_cnt < 3'(MAX_DIGITS)) begin
                        // entry <= 99999 here, so entry*10+d stays within 20 bits
                        entry_n = (entry << 3) + (entry << 1) + {16'd0, act.digit};
                        cnt_n   = digit_cnt + 3'd1;
`ifdef KEYPAD_BCD_OUT_EN
                        bcd_n   = {entry_bcd[19:0], act.digit};
`endif
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                BACKSPACE: begin
                    if (digit_cnt != 3'd0) begin
                        entry_n = entry / 20'd10;
                        cnt_n   = digit_cnt - 3'd1;
`ifdef KEYPAD_BCD_OUT_EN
                        bcd_n   = {4'd0, entry_bcd[23:4]};
`endif
                    end
                end
                CLEAR: begin
                    entry_n = 20'd0;
                    cnt_n   = 3'd0;
                    ovf_n   = 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
                    bcd_n   = 24'd0;
`endif
                end
                ENTER: begin
                    if (digit_cnt != 3'd0) begin
                        value_n = entry;
                        vv_n    = 1'b1;
                        entry_n = 20'd0;
                        cnt_n   = 3'd0;
                        ovf_n   = 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
                        bcd_n   = 24'd0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Register key strobe, code and accumulator state together
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code    <= 4'd0;
            key_pulse   <= 1'b0;
            entry       <= 20'd0;
            digit_cnt   <= 3'd0;
            overflow    <= 1'b0;
            value       <= 20'd0;
            value_valid <= 1'b0;
`ifdef KEYPAD_BCD_OUT_EN
            entry_bcd   <= 24'd0;
`endif
        end else begin
            key_pulse   <= ev_valid;
            if (ev_valid)
                key_code <= ev_code;
            entry       <= entry_n;
            digit_cnt   <= cnt_n;
            overflow    <= ovf_n;
            value       <= value_n;
            value_valid <= vv_n;
`ifdef KEYPAD_BCD_OUT_EN
            entry_bcd   <= bcd_n;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
module tb_keypad_entry;

    localparam int FRAME = 16;
    localparam int HOLD  = 6 * FRAME;

    localparam int K_1 = 0,  K_2 = 1,  K_3 = 2,  K_A = 3;
    localparam int K_4 = 4,  K_5 = 5,  K_6 = 6,  K_B = 7;
    localparam int K_7 = 8,  K_9 = 10;
    localparam int K_STAR = 12, K_HASH = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic [19:0] entry;
    logic [2:0]  digit_cnt;
    logic        overflow;
    logic [19:0] value;
    logic        value_valid;
`ifdef KEYPAD_BCD_OUT_EN
    logic [23:0] entry_bcd;
`endif

    logic [15:0] pressed = 16'd0;
    int total  = 0;
    int passed = 0;
    int pulse_cnt = 0;
    int vv_cnt = 0;

    always #5 clk = ~clk;

    keypad_entry #(.SCAN_DIV(4), .DEB_FRAMES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_code    (key_code),
        .key_pulse   (key_pulse),
        .entry       (entry),
        .digit_cnt   (digit_cnt),
        .overflow    (overflow),
        .value       (value),
`ifdef KEYPAD_BCD_OUT_EN
        .entry_bcd   (entry_bcd),
`endif
        .value_valid (value_valid)
    );

    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!key_row[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4 + c]) key_col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_pulse)   pulse_cnt++;
        if (value_valid) vv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int k);
        pressed = 16'd0;
        pressed[k] = 1'b1;
        wait_cyc(HOLD);
        pressed = 16'd0;
        wait_cyc(HOLD);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_row"},   32'(key_row), 32'hE);
        check({tag, "_code"},  32'(key_code), 0);
        check({tag, "_pulse"}, 32'(key_pulse), 0);
        check({tag, "_entry"}, 32'(entry), 0);
        check({tag, "_cnt"},   32'(digit_cnt), 0);
        check({tag, "_ovf"},   32'(overflow), 0);
        check({tag, "_value"}, 32'(value), 0);
        check({tag, "_vv"},    32'(value_valid), 0);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        wait_cyc(3);
        check_reset_state("init");
        rst = 1'b0;
        wait_cyc(2 * FRAME);

        // 1,2,3 then enter
        p0 = pulse_cnt;
        tap(K_1); check("e1", 32'(entry), 1);
        tap(K_2); check("e12", 32'(entry), 12);
        tap(K_3); check("e123", 32'(entry), 123);
        check("cnt3", 32'(digit_cnt), 3);
        check("code3", 32'(key_code), K_3);
        check("pulses3", 32'(pulse_cnt - p0), 3);
        tap(K_HASH);
        check("val123", 32'(value), 123);
        check("vv1", 32'(vv_cnt), 1);
        check("entry_after_enter", 32'(entry), 0);
        check("cnt_after_enter", 32'(digit_cnt), 0);

        // key 5 bounces for less than one frame
        p0 = pulse_cnt;
        pressed[K_5] = 1'b1;
        wait_cyc(10);
        pressed = 16'd0;
        wait_cyc(HOLD);
        check("bounce_pulse", 32'(pulse_cnt - p0), 0);
        check("bounce_entry", 32'(entry), 0);

        // 4,5,backspace, clear, enter with nothing held
        tap(K_4); tap(K_5); tap(K_A);
        check("bs_entry", 32'(entry), 4);
        check("bs_cnt", 32'(digit_cnt), 1);
        tap(K_STAR);
        check("clr_entry", 32'(entry), 0);
        check("clr_cnt", 32'(digit_cnt), 0);
        tap(K_HASH);
        check("empty_enter_vv", 32'(vv_cnt), 1);
        check("empty_enter_val", 32'(value), 123);

        // backspace on empty, then B is a pulse only
        tap(K_A);
        check("bs_empty_cnt", 32'(digit_cnt), 0);
        p0 = pulse_cnt;
        tap(K_B);
        check("b_pulse", 32'(pulse_cnt - p0), 1);
        check("b_code", 32'(key_code), K_B);
        check("b_entry", 32'(entry), 0);

        // two keys together produce nothing; a later single key works
        p0 = pulse_cnt;
        pressed = 16'd0;
        pressed[K_1] = 1'b1;
        pressed[K_2] = 1'b1;
        wait_cyc(HOLD);
        pressed = 16'd0;
        wait_cyc(HOLD);
        check("multi_pulse", 32'(pulse_cnt - p0), 0);
        tap(K_3);
        check("after_multi_entry", 32'(entry), 3);
        tap(K_STAR);

        // seven digits overflow at six
        tap(K_1); tap(K_2); tap(K_3); tap(K_4); tap(K_5); tap(K_6); tap(K_7);
        check("ovf_entry", 32'(entry), 123456);
        check("ovf_cnt", 32'(digit_cnt), 6);
        check("ovf_flag", 32'(overflow), 1);
        tap(K_HASH);
        check("ovf_value", 32'(value), 123456);
        check("ovf_cleared", 32'(overflow), 0);
        check("vv2", 32'(vv_cnt), 2);

        // held key gives one event only
        p0 = pulse_cnt;
        pressed = 16'd0;
        pressed[K_5] = 1'b1;
        wait_cyc(10 * FRAME);
        pressed = 16'd0;
        wait_cyc(HOLD);
        check("hold_pulse", 32'(pulse_cnt - p0), 1);
        check("hold_entry", 32'(entry), 5);
        tap(K_STAR);

        // reset mid-entry
        tap(K_9); tap(K_9);
        check("e99", 32'(entry), 99);
        rst = 1'b1;
        wait_cyc(1);
        check_reset_state("midrst");
        rst = 1'b0;
        wait_cyc(HOLD);

        // key held through reset yields one event afterwards
        pressed = 16'd0;
        pressed[K_7] = 1'b1;
        wait_cyc(HOLD);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        p0 = pulse_cnt;
        wait_cyc(HOLD);
        check("thru_rst_pulse", 32'(pulse_cnt - p0), 1);
        check("thru_rst_entry", 32'(entry), 7);
        check("thru_rst_code", 32'(key_code), K_7);
        pressed = 16'd0;
        wait_cyc(HOLD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each keypad row is driven before its columns are sampled.
REQ-002 Parameter DEB_FRAMES, default 4: consecutive identical full-keypad scans required before a key state is accepted.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 key_row  out  4  row drive, active-low one-hot.
REQ-006 key_col  in  4  column sense, active-low (pulled up), asynchronous to clk.
REQ-007 key_code  out  4  last accepted key, row*4+col.
REQ-008 key_pulse  out  1  one-cycle strobe per accepted key press.
REQ-009 entry  out  20  binary value of the digits entered so far.
REQ-010 digit_cnt  out  3  digits held in entry, 0..6.
REQ-011 overflow  out  1  sticky; a digit was rejected because 6 digits were already held.
REQ-012 value  out  20  last committed number.
REQ-013 value_valid  out  1  one-cycle strobe when value is updated.

Function
REQ-014 key_col shall pass through a 2-flop synchronizer before any use.
REQ-015 Rows shall be driven 0,1,2,3 cyclically, each for SCAN_DIV cycles; synced columns sampled on the last cycle of each row period; 4 rows form one 16-bit frame.
REQ-016 Frame accepted as stable after DEB_FRAMES consecutive identical frames; any differing frame restarts the count.
REQ-017 Accepted transition from zero keys pressed to exactly one key pressed = one key event; all other transitions produce no event.
REQ-018 Multiple simultaneous keys: no event; no further event until an accepted all-released frame.
REQ-019 A held key shall produce exactly one event (no repeat).
REQ-020 Legend: row0 1 2 3 A; row1 4 5 6 B; row2 7 8 9 C; row3 * 0 # D.
REQ-021 key_pulse and key_code shall be asserted one cycle after acceptance; entry, digit_cnt, overflow, value, value_valid update in that same cycle.
REQ-022 Digit, digit_cnt<6: entry=entry*10+d, digit_cnt+1.
REQ-023 Digit, digit_cnt==6: entry unchanged, overflow=1.
REQ-024 'A' (backspace): digit_cnt>0 -> entry=entry/10, digit_cnt-1; digit_cnt==0 -> no change.
REQ-025 '*' (clear): entry=0, digit_cnt=0, overflow=0.
REQ-026 '#' (enter), digit_cnt>0: value=entry, value_valid=1 for one cycle, entry=0, digit_cnt=0, overflow=0.
REQ-027 '#' with digit_cnt==0: no value_valid, no state change.
REQ-028 B, C, D: key_pulse and key_code only; entry state unchanged.
REQ-029 entry shall never exceed 999999; 20-bit width shall hold it without truncation.

Reset
REQ-030 rst shall clear: key_row=4'b1110, scan counter, synchronizer, frame history and debounce count (baseline = no key pressed), key_code=0, key_pulse=0, entry=0, digit_cnt=0, overflow=0, value=0, value_valid=0.
REQ-031 rst mid-entry shall discard partial entry; a key held through reset shall yield one event after DEB_FRAMES stable frames.

Configuration
REQ-032 With KEYPAD_BCD_OUT_EN defined: extra output entry_bcd[23:0], entry as 6 BCD digits, most significant in [23:20], reset 0, updated with entry.
REQ-033 Without KEYPAD_BCD_OUT_EN: port and its logic absent; all other behaviour identical.

Structure
REQ-034 Package keypad_pkg shall hold the legend-to-function table, function codes (DIGIT, BACKSPACE, CLEAR, ENTER, NONE), MAX_DIGITS=6, and default parameter values.
REQ-035 Sub-module keypad_scan shall contain row drive, synchronizer, debounce and event detection; keypad_entry shall contain decode and accumulation.

Verification (SCAN_DIV=4, DEB_FRAMES=2)
REQ-036 Press/release 1,2,3,# -> three key_pulse with entry 1,12,123; then value=123, value_valid one cycle, entry=0.
REQ-037 Key 5 bouncing for one frame then released -> no key_pulse, entry unchanged.
REQ-038 1,2,3,4,5,6,7 -> entry=123456, digit_cnt=6, overflow=1; # -> value=123456, overflow=0.
REQ-039 4,5,A -> entry=4, digit_cnt=1; * -> entry=0, digit_cnt=0; # -> no value_valid.
REQ-040 Keys 1 and 2 pressed together, then released -> no key_pulse; 3 pressed -> entry=3.
REQ-041 rst asserted after digits 9,9 -> all outputs at REQ-030 values the cycle after rst is sampled.
